mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of one single-port RAM
// (synchronous write, asynchronous read).
//
// The fetch port is read-only. The data port does loads and stores.
// A port is granted in the same cycle that it requests. On contention
// the data port has fixed priority. Read data is registered and comes
// back one cycle after the grant, with a one-cycle rvalid pulse.
//
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to enable the
// starvation guard. Fetch is then forced through after STARVE_LIMIT
// consecutive data grants while fetch waits.
//
// Ports:
//   i_CLK, i_RST               clock, asynchronous active-high reset
//   i_if_req, i_if_addr        fetch read request and address
//   o_if_gnt                   fetch access performed this cycle
//   o_if_rvalid, o_if_rdata    registered fetch read data
//   i_d_req, i_d_we            data request; 1 = store, 0 = load
//   i_d_addr, i_d_wdata        data address and store data
//   o_d_gnt                    data access performed this cycle
//   o_d_rvalid, o_d_rdata      registered load data
//   o_mem_addr, o_mem_data,
//   o_mem_we                   RAM address, write data, write enable
//   i_mem_q                    RAM asynchronous read data
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  output logic [DATA_WIDTH-1:0] o_if_rdata,
  input  logic                  i_d_req,
  input  logic                  i_d_we,
  input  logic [ADDR_WIDTH-1:0] i_d_addr,
  input  logic [DATA_WIDTH-1:0] i_d_wdata,
  output logic                  o_d_gnt,
  output logic                  o_d_rvalid,
  output logic [DATA_WIDTH-1:0] o_d_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic                  o_mem_we,
  input  logic [DATA_WIDTH-1:0] i_mem_q
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_limit_check
    $error("mem_arbiter: STARVE_LIMIT must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, SERV_I, SERV_D} state_t;

  state_t last_q, last_d;
  logic   if_gnt, d_gnt;
  logic   starve_hit;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] LIMIT8 = STARVE_LIMIT[7:0];
  logic [7:0] starve_q;

  // Counts data grants taken while fetch waits. It clears as soon as
  // fetch is served or drops its request. The guard fires only when
  // both ports request, so the count never goes past LIMIT8.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST)                    starve_q <= '0;
    else if (if_gnt || !i_if_req) starve_q <= '0;
    else if (d_gnt)               starve_q <= starve_q + 8'd1;
  end

  assign starve_hit = (starve_q >= LIMIT8);
`else
  assign starve_hit = 1'b0;
`endif

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) last_q <= IDLE;
    else       last_q <= last_d;
  end

  // Grants depend only on the current requests, so a lone request is
  // served in any state. Reset blocks all grants, so no store can
  // commit while reset is high.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    last_d = IDLE;
    if (!i_RST) begin
      if (i_d_req && !(i_if_req && starve_hit)) d_gnt  = 1'b1;
      else if (i_if_req)                        if_gnt = 1'b1;
    end
    if (if_gnt)     last_d = SERV_I;
    else if (d_gnt) last_d = SERV_D;
  end

  assign o_if_gnt   = if_gnt;
  assign o_d_gnt    = d_gnt;
  assign o_mem_we   = d_gnt & i_d_we;
  assign o_mem_addr = d_gnt ? i_d_addr : i_if_addr;
  assign o_mem_data = i_d_wdata;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      o_if_rvalid <= 1'b0;
      o_if_rdata  <= '0;
      o_d_rvalid  <= 1'b0;
      o_d_rdata   <= '0;
    end else begin
      o_if_rvalid <= if_gnt;
      o_d_rvalid  <= d_gnt & ~i_d_we;
      if (if_gnt)            o_if_rdata <= i_mem_q;
      if (d_gnt && !i_d_we)  o_d_rdata  <= i_mem_q;
    end
  end

  a_last_fetch: assert property (@(posedge i_CLK) disable iff (i_RST)
    if_gnt |=> (last_q == SERV_I));
  a_last_data: assert property (@(posedge i_CLK) disable iff (i_RST)
    d_gnt |=> (last_q == SERV_D));

endmodule
